// File: rtl/nqcpu_pkg.sv
// nqcpu_pkg: types and constants shared by the nqcpu pipeline stages
//   mem_op_t     memory operation requested by the ALU stage
//   mas_state_t  mem_access_stage FSM states
//   mem_req_t    request fields latched by mem_access_stage on en
package nqcpu_pkg;
    localparam int CTRL_W        = 22;
    localparam int CTRL_DATA_LSB = 0;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_DONE
    } mas_state_t;

    typedef struct packed {
        mem_op_t           op;
        logic              is_byte;
        logic              sext;
        logic [15:0]       addr;
        logic [15:0]       wdata;
        logic [15:0]       result;
        logic [CTRL_W-1:0] ctrl;
    } mem_req_t;
endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: shared 16-bit memory bus
//   mem_addr_o   word-aligned bus address (master -> slave)
//   mem_re_o     read strobe              (master -> slave)
//   mem_we_o     write strobe             (master -> slave)
//   mem_wdata_o  write data               (master -> slave)
//   mem_rdata_i  read data                (slave -> master)
//   mem_wait_i   stall current phase      (slave -> master)
interface mem_access_stage_if;
    logic [15:0] mem_addr_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic [15:0] mem_wdata_o;
    logic [15:0] mem_rdata_i;
    logic        mem_wait_i;

    modport master (
        output mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
        input  mem_rdata_i, mem_wait_i
    );

    modport slave (
        input  mem_addr_o, mem_re_o, mem_we_o, mem_wdata_o,
        output mem_rdata_i, mem_wait_i
    );
endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian byte-lane select/extend for loads and merge for byte stores
//   hi          address bit 0: 0 selects [7:0], 1 selects [15:8]
//   is_byte     1 = byte access, 0 = word access
//   sext        byte load sign-extends when 1
//   rdata       word read from the bus
//   wdata       store data; a byte store uses [7:0]
//   load_data   extended load value
//   store_word  word to write back (read word with one lane replaced for byte stores)
module mem_lane_align (
    input  logic        hi,
    input  logic        is_byte,
    input  logic        sext,
    input  logic [15:0] rdata,
    input  logic [15:0] wdata,
    output logic [15:0] load_data,
    output logic [15:0] store_word
);
    logic [7:0] lane;

    always_comb begin
        lane       = hi ? rdata[15:8] : rdata[7:0];
        load_data  = is_byte ? {{8{sext & lane[7]}}, lane} : rdata;
        store_word = !is_byte ? wdata : hi ? {wdata[7:0], rdata[7:0]} : {rdata[15:8], wdata[7:0]};
    end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: load/store stage between alu_stage and regWrite_stage
//   clk, rst_n   clock, synchronous active-low reset
//   en           start pulse, ignored while busy_o
//   op_i, byte_i, sext_i, addr_i, wdata_i, result_i, ctrl_i   request latched on en
//   bus          memory bus master port
//   ctrl_o       ctrl bundle with data field replaced (valid from done_o, held until next completion)
//   busy_o       transaction in progress
//   done_o       one-cycle completion pulse
//   fault_o      with done_o: misaligned word access or bus timeout
module mem_access_stage
    import nqcpu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  mem_op_t           op_i,
    input  logic              byte_i,
    input  logic              sext_i,
    input  logic [15:0]       addr_i,
    input  logic [15:0]       wdata_i,
    input  logic [15:0]       result_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    mem_access_stage_if.master bus,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              fault_o
);
    // Wait cycles counted 0..TIMEOUT-1; a wait seen at the last count ends the phase.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mas_state_t        state_q, state_d;
    mem_req_t          req_q, req_d;
    logic [15:0]       rdata_q, rdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              flt_q, flt_d;
    logic              done_q, done_d;
    logic              fault_q, fault_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [15:0]       load_data, store_word, data_sel;
    logic              misaligned;

    mem_lane_align u_align (
        .hi        (req_q.addr[0]),
        .is_byte   (req_q.is_byte),
        .sext      (req_q.sext),
        .rdata     (rdata_q),
        .wdata     (req_q.wdata),
        .load_data (load_data),
        .store_word(store_word)
    );

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        flt_d      = flt_q;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        ctrl_d     = ctrl_q;
        misaligned = (op_i == MEM_LOAD || op_i == MEM_STORE) && addr_i[0] && !byte_i;
        // Faulted loads return 0; stores keep the incoming data field.
        data_sel   = req_q.op == MEM_NONE ? req_q.result :
                     req_q.op != MEM_LOAD ? req_q.ctrl[CTRL_DATA_LSB +: 16] :
                     flt_q ? 16'h0000 : load_data;
        case (state_q)
            S_IDLE: if (en) begin
                req_d   = '{op: op_i, is_byte: byte_i, sext: sext_i, addr: addr_i,
                            wdata: wdata_i, result: result_i, ctrl: ctrl_i};
                flt_d   = misaligned;
                cnt_d   = '0;
                state_d = (misaligned || !(op_i == MEM_LOAD || op_i == MEM_STORE)) ? S_DONE :
                          (op_i == MEM_LOAD || byte_i) ? S_RD : S_WR;
            end
            S_RD: if (!bus.mem_wait_i) begin
                rdata_d = bus.mem_rdata_i;
                cnt_d   = '0;
                state_d = req_q.op == MEM_LOAD ? S_DONE : S_WR;
            end else if (cnt_q == TO_LAST) begin
                flt_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                cnt_d   = cnt_q + 8'd1;
            end
            S_WR: if (!bus.mem_wait_i) begin
                state_d = S_DONE;
            end else if (cnt_q == TO_LAST) begin
                flt_d   = 1'b1;
                state_d = S_DONE;
            end else begin
                cnt_d   = cnt_q + 8'd1;
            end
            S_DONE: begin
                done_d  = 1'b1;
                fault_d = flt_q;
                ctrl_d  = req_q.ctrl;
                ctrl_d[CTRL_DATA_LSB +: 16] = data_sel;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            flt_q   <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            flt_q   <= flt_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.mem_re_o    = state_q == S_RD;
    assign bus.mem_we_o    = state_q == S_WR;
    assign bus.mem_addr_o  = {req_q.addr[15:1], 1'b0};
    assign bus.mem_wdata_o = store_word;
    assign busy_o          = state_q != S_IDLE;
    assign done_o          = done_q;
    assign fault_o         = fault_q;
    assign ctrl_o          = ctrl_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed transactions against a transaction-level model and bus slave
module tb_mem_access_stage;
    import nqcpu_pkg::*;

    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    mem_op_t           op_i;
    logic              byte_i, sext_i;
    logic [15:0]       addr_i, wdata_i, result_i;
    logic [CTRL_W-1:0] ctrl_i, ctrl_o;
    logic              busy_o, done_o, fault_o;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .op_i(op_i), .byte_i(byte_i), .sext_i(sext_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .result_i(result_i), .ctrl_i(ctrl_i),
        .bus(bus), .ctrl_o(ctrl_o), .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Bus slave: word memory, fixed number of wait cycles at the start of every phase.
    logic [15:0] mem [1024];
    int  wt = 0;
    int  wcnt = 0;
    bit  prev_act = 0;
    bit  prev_we = 0;

    assign bus.mem_rdata_i = mem[bus.mem_addr_o[10:1]];

    always @(negedge clk) begin
        if (bus.mem_re_o || bus.mem_we_o) begin
            if (!prev_act || bus.mem_we_o != prev_we) wcnt = wt;
            bus.mem_wait_i = wcnt > 0;
            if (wcnt > 0) wcnt--;
            if (bus.mem_we_o && !bus.mem_wait_i) mem[bus.mem_addr_o[10:1]] = bus.mem_wdata_o;
        end else begin
            bus.mem_wait_i = 1'b0;
        end
        prev_act = bus.mem_re_o || bus.mem_we_o;
        prev_we  = bus.mem_we_o;
    end

    // Expected transaction, derived from the request, the memory contents and the wait count.
    int          rd_len, wr_len, lat, t_en = 0, t_done = 0;
    logic [21:0] exp_ctrl, hold_ctrl = '0, got_ctrl;
    logic [15:0] exp_addr, exp_wdata, got_wdata;
    logic        exp_fault, got_fault;
    int          n_re, n_we, done_at;
    bit          active = 0;

    task automatic model(input mem_op_t op, input logic b, s, input logic [15:0] a, wd, res,
                         input logic [21:0] c, input int w);
        logic mis, hrd, hwr, tord, towr;
        logic [15:0] word, val;
        logic [7:0] lane;
        logic [3:0] sh;
        mis  = (op == MEM_LOAD || op == MEM_STORE) && a[0] && !b;
        hrd  = !mis && (op == MEM_LOAD || (op == MEM_STORE && b));
        hwr  = !mis && op == MEM_STORE;
        tord = hrd && w >= TO;
        towr = hwr && !tord && w >= TO;
        rd_len = hrd ? (tord ? TO : w + 1) : 0;
        wr_len = (hwr && !tord) ? (towr ? TO : w + 1) : 0;
        lat  = rd_len + wr_len + 2;
        sh   = a[0] ? 4'd8 : 4'd0;
        word = mem[a[10:1]];
        lane = 8'(word >> sh);
        val  = !b ? word : s ? 16'($signed(lane)) : 16'(lane);
        exp_fault = mis || tord || towr;
        exp_ctrl  = {c[21:16], op == MEM_NONE ? res : op == MEM_LOAD ? (exp_fault ? 16'h0 : val) : c[15:0]};
        exp_addr  = {a[15:1], 1'b0};
        exp_wdata = !b ? wd : (word & ~(16'h00FF << sh)) | (16'(wd[7:0]) << sh);
    endtask

    always @(negedge clk) begin
        int k;
        if (active) begin
            if (bus.mem_re_o) n_re++;
            if (bus.mem_we_o) n_we++;
            chk("strobe excl", 32'(bus.mem_re_o && bus.mem_we_o), 32'd0);
            if (cyc > t_en && cyc <= t_done) begin
                k = cyc - t_en;
                chk("re", 32'(bus.mem_re_o), 32'(k <= rd_len));
                chk("we", 32'(bus.mem_we_o), 32'(k > rd_len && k <= rd_len + wr_len));
                chk("busy", 32'(busy_o), 32'(k < lat));
                chk("done", 32'(done_o), 32'(k == lat));
                if (bus.mem_re_o || bus.mem_we_o) chk("addr", 32'(bus.mem_addr_o), 32'(exp_addr));
                if (bus.mem_we_o) begin
                    chk("wdata", 32'(bus.mem_wdata_o), 32'(exp_wdata));
                    got_wdata = bus.mem_wdata_o;
                end
                if (done_o) begin
                    chk("ctrl_o", 32'(ctrl_o), 32'(exp_ctrl));
                    chk("fault", 32'(fault_o), 32'(exp_fault));
                    hold_ctrl = exp_ctrl;
                    got_ctrl  = ctrl_o;
                    got_fault = fault_o;
                    done_at   = k;
                end else begin
                    chk("fault idle", 32'(fault_o), 32'd0);
                end
            end else begin
                chk("idle re", 32'(bus.mem_re_o), 32'd0);
                chk("idle we", 32'(bus.mem_we_o), 32'd0);
                chk("idle busy", 32'(busy_o), 32'd0);
                chk("idle done", 32'(done_o), 32'd0);
                chk("ctrl hold", 32'(ctrl_o), 32'(hold_ctrl));
            end
        end
    end

    task automatic run(input mem_op_t op, input logic b, s, input logic [15:0] a, wd, res,
                       input logic [21:0] c, input int w, input int glitch_k, input int rst_k);
        model(op, b, s, a, wd, res, c, w);
        wt = w;
        @(negedge clk);
        op_i = op; byte_i = b; sext_i = s; addr_i = a; wdata_i = wd; result_i = res; ctrl_i = c;
        en = 1'b1;
        n_re = 0; n_we = 0; done_at = 0; got_ctrl = '0; got_fault = 1'b0; got_wdata = '0;
        t_en = cyc;
        t_done = cyc + lat;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            en = (k == glitch_k);
            if (k == glitch_k) begin
                op_i = MEM_STORE; byte_i = 1'b0; addr_i = 16'h0002; wdata_i = 16'hDEAD;
            end
            if (k == rst_k) begin
                active = 0;
                rst_n = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        rst_n = 1'b0; en = 1'b0; op_i = MEM_NONE; byte_i = 1'b0; sext_i = 1'b0;
        addr_i = '0; wdata_i = '0; result_i = '0; ctrl_i = '0;
        repeat (3) @(negedge clk);
        chk("rst re", 32'(bus.mem_re_o), 32'd0);
        chk("rst we", 32'(bus.mem_we_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(done_o), 32'd0);
        chk("rst fault", 32'(fault_o), 32'd0);
        chk("rst addr", 32'(bus.mem_addr_o), 32'd0);
        chk("rst wdata", 32'(bus.mem_wdata_o), 32'd0);
        chk("rst ctrl", 32'(ctrl_o), 32'd0);
        rst_n = 1'b1;
        active = 1;

        mem[10'h080] = 16'hBEEF;
        run(MEM_LOAD, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 22'h2A1111, 0, 0, 0);
        chk("t1 ctrl", 32'(got_ctrl), 32'h2ABEEF);
        chk("t1 lat", 32'(done_at), 32'd3);
        chk("t1 nre", 32'(n_re), 32'd1);

        mem[10'h080] = 16'h80AA;
        run(MEM_LOAD, 1'b1, 1'b1, 16'h0101, 16'h0000, 16'h0000, 22'h000000, 3, 0, 0);
        chk("t2 ctrl", 32'(got_ctrl), 32'h00FF80);
        chk("t2 lat", 32'(done_at), 32'd6);

        mem[10'h100] = 16'h1234;
        run(MEM_STORE, 1'b1, 1'b0, 16'h0200, 16'h0055, 16'h0000, 22'h01CAFE, 0, 0, 0);
        chk("t3 wdata", 32'(got_wdata), 32'h1255);
        chk("t3 nwe", 32'(n_we), 32'd1);
        chk("t3 lat", 32'(done_at), 32'd4);
        chk("t3 mem", 32'(mem[10'h100]), 32'h1255);
        chk("t3 ctrl", 32'(got_ctrl), 32'h01CAFE);

        run(MEM_STORE, 1'b0, 1'b0, 16'h0003, 16'hABCD, 16'h0000, 22'h000777, 0, 0, 0);
        chk("t4 nre", 32'(n_re), 32'd0);
        chk("t4 nwe", 32'(n_we), 32'd0);
        chk("t4 fault", 32'(got_fault), 32'd1);
        chk("t4 lat", 32'(done_at), 32'd2);

        run(MEM_LOAD, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'h0000, 22'h15AAAA, 1000, 0, 0);
        chk("t5 nre", 32'(n_re), 32'd4);
        chk("t5 fault", 32'(got_fault), 32'd1);
        chk("t5 ctrl", 32'(got_ctrl), 32'h150000);
        chk("t5 lat", 32'(done_at), 32'd6);

        run(MEM_NONE, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h7777, 22'h3FFFFF, 0, 0, 0);
        chk("none ctrl", 32'(got_ctrl), 32'h3F7777);
        chk("none fault", 32'(got_fault), 32'd0);
        chk("none lat", 32'(done_at), 32'd2);

        mem[10'h0C0] = 16'hC33C;
        run(MEM_LOAD, 1'b1, 1'b0, 16'h0181, 16'h0000, 16'h0000, 22'h000000, 3, 2, 0);
        chk("busy-en ctrl", 32'(got_ctrl), 32'h0000C3);
        chk("busy-en lat", 32'(done_at), 32'd6);
        chk("busy-en nwe", 32'(n_we), 32'd0);

        run(MEM_LOAD, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h0000, 22'h3FFFFF, 0, 0, 0);
        chk("misld ctrl", 32'(got_ctrl), 32'h3F0000);
        chk("misld fault", 32'(got_fault), 32'd1);

        mem[10'h020] = 16'h0000;
        run(MEM_STORE, 1'b0, 1'b0, 16'h0040, 16'h9876, 16'h0000, 22'h000000, 2, 0, 0);
        chk("wst mem", 32'(mem[10'h020]), 32'h9876);
        chk("wst lat", 32'(done_at), 32'd5);

        run(MEM_STORE, 1'b1, 1'b0, 16'h0041, 16'h00EE, 16'h0000, 22'h000000, 1, 0, 0);
        chk("bst hi mem", 32'(mem[10'h020]), 32'hEE76);
        chk("bst hi wdata", 32'(got_wdata), 32'hEE76);
        chk("bst hi lat", 32'(done_at), 32'd6);

        mem[10'h030] = 16'h1111;
        run(MEM_STORE, 1'b0, 1'b0, 16'h0060, 16'h2222, 16'h0000, 22'h000000, 1000, 0, 0);
        chk("wto fault", 32'(got_fault), 32'd1);
        chk("wto mem", 32'(mem[10'h030]), 32'h1111);
        chk("wto nwe", 32'(n_we), 32'd4);

        mem[10'h180] = 16'h5A5A;
        run(MEM_STORE, 1'b0, 1'b0, 16'h0300, 16'hAAAA, 16'h0000, 22'h000000, 1000, 0, 2);
        @(negedge clk);
        chk("mrst we", 32'(bus.mem_we_o), 32'd0);
        chk("mrst re", 32'(bus.mem_re_o), 32'd0);
        chk("mrst busy", 32'(busy_o), 32'd0);
        chk("mrst done", 32'(done_o), 32'd0);
        chk("mrst ctrl", 32'(ctrl_o), 32'd0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mrst no done", 32'(done_o), 32'd0);
        end
        chk("mrst mem", 32'(mem[10'h180]), 32'h5A5A);
        hold_ctrl = '0;
        active = 1;
        run(MEM_NONE, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h4321, 22'h2AAAAA, 0, 0, 0);
        chk("post ctrl", 32'(got_ctrl), 32'h2A4321);
        chk("post lat", 32'(done_at), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
